u_dec_stage: RTL and testbench
==============================

# u_dec_stage

Registered RV32I integer decode stage that produces the operation code and operands for the integer ALU. It accepts one fetched instruction per handshake, reads the register file combinationally, and decodes OP, OP-IMM, LUI and AUIPC. It registers `alu_op`, `alu_i1`, `alu_i2` and writeback control into a single valid/ready pipeline slot. The ALU consumes these outputs directly.

## Interface
Parameters:
- `CNT_W`, 8, width of the saturating illegal-instruction counter.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `flush`  input  1  discard the slot contents and any instruction offered this cycle.
- `if_valid`  input  1  instruction offered.
- `if_ready`  output  1  stage can accept.
- `if_instr`  input  32  instruction word.
- `if_pc`  input  32  PC of `if_instr`.
- `rs1_addr`  output  5  register-file read address, equal to `if_instr[19:15]` (combinational).
- `rs2_addr`  output  5  register-file read address, equal to `if_instr[24:20]` (combinational).
- `rs1_data`  input  32  read data for `rs1_addr`, same cycle.
- `rs2_data`  input  32  read data for `rs2_addr`, same cycle.
- `ex_valid`  output  1  slot holds a decoded instruction.
- `ex_ready`  input  1  downstream takes the slot.
- `alu_op`  output  4  ALU operation code.
- `alu_i1`  output  32  ALU operand 1.
- `alu_i2`  output  32  ALU operand 2.
- `rd_addr`  output  5  destination register.
- `rd_we`  output  1  writeback enable.
- `illegal`  output  1  slot holds an unsupported or malformed instruction.
- `illegal_cnt`  output  CNT_W  count of illegal instructions accepted.

## Operation
ALU op codes:
- ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.

Decode by opcode `if_instr[6:0]`:
- OP (0110011):
  - `alu_op = {f7[5], f3}`, `alu_i1 = rs1_data`, `alu_i2 = rs2_data`.
  - Legal only if f7 is 0000000, or f7 is 0100000 with f3 equal to 000 or 101.
- OP-IMM (0010011):
  - `alu_i1 = rs1_data`, `alu_i2 = sign-extended imm[31:20]`.
  - When f3 is 101: `alu_op = {instr[30], 101}`; legal only if `instr[31:25]` is 0000000 or 0100000.
  - When f3 is 001: `alu_op = 0001`; legal only if `instr[31:25]` is 0000000.
  - All other f3 values: `alu_op = {0, f3}`; always legal. There is no SUBI.
- LUI (0110111): `alu_op = 0000`, `alu_i1 = 0`, `alu_i2 = {instr[31:12], 12'h0}`.
- AUIPC (0010111): `alu_op = 0000`, `alu_i1 = if_pc`, `alu_i2 = {instr[31:12], 12'h0}`.
- Any other opcode, or a malformed encoding above, is illegal:
  - `illegal = 1`, `alu_op = 0000`, `alu_i1 = alu_i2 = 0`, `rd_we = 0`, `rd_addr = instr[11:7]`.

Writeback control:
- `rd_addr = instr[11:7]`.
- `rd_we = legal && (rd_addr != 0)`.

Slot (1-entry pipeline register):
- `if_ready = !ex_valid || ex_ready`.
- Accept occurs when `if_valid && if_ready && !flush`. On accept, all decoded fields are registered and `ex_valid = 1`.
- When `ex_valid && ex_ready` with no new accept, `ex_valid` goes to 0 and the data fields hold their last value.
- When `ex_valid && !ex_ready`, every output holds, even if `rs1_data`/`rs2_data` change.
- `flush` forces `ex_valid` to 0 next cycle and blocks the accept in the same cycle. `flush` has priority over all other events.
- `illegal_cnt` increments on each accepted illegal instruction and saturates at all-ones. A flushed illegal instruction is not counted.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction per cycle when `ex_ready` is held 1.
- `if_ready` depends combinationally on `ex_ready`; there is no combinational path from `if_valid` to `if_ready`.
- `rs1_addr`/`rs2_addr` are combinational from `if_instr`. The register file must return data in the same cycle.
- Asynchronous reset sets `ex_valid`, `illegal`, `rd_we`, `alu_op`, `alu_i1`, `alu_i2`, `rd_addr` and `illegal_cnt` to 0 immediately, independent of `clk`. Reset asserted mid-stall drops the held instruction.
- After reset release, the first accept is possible on the first rising edge.

## Test plan
- ADD then SUB:
  - `0x002081B3` with `rs1_data = 5`, `rs2_data = 7` -> next cycle `alu_op = 0000`, `alu_i1 = 5`, `alu_i2 = 7`, `rd_addr = 3`, `rd_we = 1`.
  - Then `0x402081B3` -> `alu_op = 1000`.
- SRAI and ADDI:
  - `0x40435293` -> `alu_op = 1101`, `alu_i2 = 0x00000404`, `rd_addr = 5`.
  - `0xFFF00093` with `rs1_data = 0` -> `alu_op = 0000`, `alu_i2 = 0xFFFFFFFF`, `rd_we = 1`.
- LUI and AUIPC:
  - `0x123453B7` -> `alu_i1 = 0`, `alu_i2 = 0x12345000`.
  - `0x00001397` with `if_pc = 0x100` -> `alu_op = 0000`, `alu_i1 = 0x100`, `alu_i2 = 0x1000`.
- Illegal and x0 handling:
  - `0x00000000` -> `illegal = 1`, `rd_we = 0`, `illegal_cnt` goes from 0 to 1.
  - `0x02208033` (f7 = 0000001) -> `illegal = 1`.
  - `0x00208033` (ADD to x0) -> `illegal = 0`, `rd_we = 0`.
- Stall and back-to-back:
  - Hold `ex_ready = 0` for 3 cycles with `if_valid = 1` -> `if_ready = 0`, and outputs stay stable while `rs1_data` toggles.
  - Release `ex_ready` -> next instruction appears 1 cycle later with no instruction lost or duplicated.
- Flush and reset:
  - `flush = 1` while `ex_valid = 1` and an illegal instruction is offered -> `ex_valid = 0` next cycle, `illegal_cnt` unchanged.
  - `rst_n` low between clock edges -> all outputs 0 immediately.
  - 300 accepted illegal instructions with `CNT_W = 8` -> `illegal_cnt = 255`.

Source files
------------

// File: rtl/u_dec_stage.sv
// u_dec_stage: registered RV32I integer decode stage.
// Decodes OP, OP-IMM, LUI and AUIPC into an ALU op code and two operands.
// The results are held in a single valid/ready slot. A saturating counter
// records how many illegal instructions the stage has accepted.
module u_dec_stage #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             ex_valid,
  input  logic             ex_ready,
  output logic [3:0]       alu_op,
  output logic [31:0]      alu_i1,
  output logic [31:0]      alu_i2,
  output logic [4:0]       rd_addr,
  output logic             rd_we,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_u_s;
  logic [4:0]  rd_s;

  logic [3:0]  op_s;
  logic [31:0] i1_s;
  logic [31:0] i2_s;
  logic        legal_s;
  logic        we_s;
  logic        accept_s;

  logic             ex_valid_q, ex_valid_d;
  logic [3:0]       alu_op_q;
  logic [31:0]      alu_i1_q;
  logic [31:0]      alu_i2_q;
  logic [4:0]       rd_addr_q;
  logic             rd_we_q;
  logic             illegal_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign opcode_s = if_instr[6:0];
  assign f3_s     = if_instr[14:12];
  assign f7_s     = if_instr[31:25];
  assign rd_s     = if_instr[11:7];
  assign imm_i_s  = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_u_s  = {if_instr[31:12], 12'h000};

  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  // Only the held slot gates acceptance, so if_valid never feeds back into if_ready.
  assign if_ready = !ex_valid_q || ex_ready;
  assign accept_s = if_valid && if_ready && !flush;
  assign we_s     = legal_s && (rd_s != 5'd0);

  // Decode the offered instruction; anything not recognised keeps zeroed operands.
  always_comb begin
    op_s    = 4'b0000;
    i1_s    = 32'h0000_0000;
    i2_s    = 32'h0000_0000;
    legal_s = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if ((f7_s == 7'b0000000) ||
            ((f7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101)))) begin
          legal_s = 1'b1;
          op_s    = {f7_s[5], f3_s};
          i1_s    = rs1_data;
          i2_s    = rs2_data;
        end else begin
          legal_s = 1'b0;
        end
      end
      OPC_OPIMM: begin
        case (f3_s)
          3'b101: begin
            if ((f7_s == 7'b0000000) || (f7_s == 7'b0100000)) begin
              legal_s = 1'b1;
              op_s    = {if_instr[30], 3'b101};
              i1_s    = rs1_data;
              i2_s    = imm_i_s;
            end else begin
              legal_s = 1'b0;
            end
          end
          3'b001: begin
            if (f7_s == 7'b0000000) begin
              legal_s = 1'b1;
              op_s    = 4'b0001;
              i1_s    = rs1_data;
              i2_s    = imm_i_s;
            end else begin
              legal_s = 1'b0;
            end
          end
          default: begin
            // Bit 30 is part of the immediate here: there is no SUBI.
            legal_s = 1'b1;
            op_s    = {1'b0, f3_s};
            i1_s    = rs1_data;
            i2_s    = imm_i_s;
          end
        endcase
      end
      OPC_LUI: begin
        legal_s = 1'b1;
        op_s    = 4'b0000;
        i1_s    = 32'h0000_0000;
        i2_s    = imm_u_s;
      end
      OPC_AUIPC: begin
        legal_s = 1'b1;
        op_s    = 4'b0000;
        i1_s    = if_pc;
        i2_s    = imm_u_s;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
  end

  // Slot occupancy and illegal counter next state; flush outranks accept and drain.
  always_comb begin
    ex_valid_d = ex_valid_q;
    cnt_d      = cnt_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (accept_s) begin
      ex_valid_d = 1'b1;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end else begin
      ex_valid_d = ex_valid_q;
    end
    if (accept_s && !legal_s && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Slot state registers; decoded fields load only on accept and hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      alu_op_q   <= 4'b0000;
      alu_i1_q   <= 32'h0000_0000;
      alu_i2_q   <= 32'h0000_0000;
      rd_addr_q  <= 5'd0;
      rd_we_q    <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      ex_valid_q <= ex_valid_d;
      cnt_q      <= cnt_d;
      if (accept_s) begin
        alu_op_q  <= op_s;
        alu_i1_q  <= i1_s;
        alu_i2_q  <= i2_s;
        rd_addr_q <= rd_s;
        rd_we_q   <= we_s;
        illegal_q <= !legal_s;
      end
    end
  end

  assign ex_valid    = ex_valid_q;
  assign alu_op      = alu_op_q;
  assign alu_i1      = alu_i1_q;
  assign alu_i2      = alu_i2_q;
  assign rd_addr     = rd_addr_q;
  assign rd_we       = rd_we_q;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_u_dec_stage.sv
// tb_u_dec_stage: scoreboard bench for the RV32I decode stage.
module tb_u_dec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_i1;
  logic [31:0] alu_i2;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] i1;
    logic [31:0] i2;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_cnt  = 0;

  u_dec_stage #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_op(alu_op), .alu_i1(alu_i1), .alu_i2(alu_i2),
    .rd_addr(rd_addr), .rd_we(rd_we), .illegal(illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] i1, input logic [31:0] i2,
                              input logic [4:0] rd, input logic we, input logic ill);
    exp_t e;
    e.op = op; e.i1 = i1; e.i2 = i2; e.rd = rd; e.we = we; e.ill = ill;
    return e;
  endfunction

  // Scoreboard: every slot consumed by the ALU must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      exp_t got, want;
      got = mk(alu_op, alu_i1, alu_i2, rd_addr, rd_we, illegal);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got slot %h required no output", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL sb_slot: got op=%h i1=%h i2=%h rd=%0d we=%b ill=%b required op=%h i1=%h i2=%h rd=%0d we=%b ill=%b",
                   got.op, got.i1, got.i2, got.rd, got.we, got.ill,
                   want.op, want.i1, want.i2, want.rd, want.we, want.ill);
        end
      end
    end
  end

  // Offer one instruction, wait (bounded) for acceptance, record the expectation.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                      input logic [31:0] r2, input exp_t e);
    bit ok;
    ok = 1'b0;
    if_instr = instr; if_pc = pc; rs1_data = r1; rs2_data = r2; if_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (if_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (ok) begin
      sb.push_back(e);
      if (e.ill && exp_cnt != 255) exp_cnt++;
    end else begin
      failures++;
      $display("FAIL send_accept: got if_ready=0 for 20 cycles required acceptance of %h", instr);
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    if_instr = 32'h0; if_pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    #12;
    checks++;
    if ({ex_valid, illegal, rd_we, alu_op, alu_i1, alu_i2, rd_addr, illegal_cnt} !== 84'h0 || if_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: got v=%b ill=%b we=%b op=%h i1=%h i2=%h rd=%0d cnt=%0d rdy=%b required all zero, rdy=1",
               ex_valid, illegal, rd_we, alu_op, alu_i1, alu_i2, rd_addr, illegal_cnt, if_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_op();
    if_instr = 32'h002081B3; #1;
    checks++;
    if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
      failures++;
      $display("FAIL rf_addr: got rs1=%0d rs2=%0d required rs1=1 rs2=2", rs1_addr, rs2_addr);
    end
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, mk(4'b0000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
    send(32'h402081B3, 32'h0, 32'd5, 32'd7, mk(4'b1000, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
  endtask

  task automatic test_opimm();
    send(32'h40435293, 32'h0, 32'h8000_0000, 32'h0, mk(4'b1101, 32'h8000_0000, 32'h0000_0404, 5'd5, 1'b1, 1'b0));
    send(32'hFFF00093, 32'h0, 32'h0, 32'h55, mk(4'b0000, 32'h0, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0));
    send(32'hFFF0C093, 32'h0, 32'h0F0F_0F0F, 32'h0, mk(4'b0100, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd1, 1'b1, 1'b0));
    send(32'h40000093, 32'h0, 32'h3, 32'h0, mk(4'b0000, 32'h3, 32'h0000_0400, 5'd1, 1'b1, 1'b0));
    send(32'h02009093, 32'h0, 32'h3, 32'h0, mk(4'b0000, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1));
  endtask

  task automatic test_upper();
    send(32'h123453B7, 32'h0, 32'hDEAD_BEEF, 32'h0, mk(4'b0000, 32'h0, 32'h1234_5000, 5'd7, 1'b1, 1'b0));
    send(32'h00001397, 32'h100, 32'hDEAD_BEEF, 32'h0, mk(4'b0000, 32'h100, 32'h0000_1000, 5'd7, 1'b1, 1'b0));
  endtask

  task automatic test_illegal();
    send(32'h00000000, 32'h40, 32'h1111_1111, 32'h2222_2222, mk(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    send(32'h02208033, 32'h44, 32'h1111_1111, 32'h2222_2222, mk(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    send(32'h00208033, 32'h48, 32'd9, 32'd4, mk(4'b0000, 32'd9, 32'd4, 5'd0, 1'b0, 1'b0));
    @(negedge clk);
    checks++;
    if (illegal_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL illegal_cnt: got %0d required %0d", illegal_cnt, exp_cnt);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    ex_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd11, 32'd22, mk(4'b0000, 32'd11, 32'd22, 5'd3, 1'b1, 1'b0));
    if_instr = 32'h402081B3; rs1_data = 32'd100; rs2_data = 32'd40; if_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b0 || {ex_valid, alu_op, alu_i1, alu_i2} !== {1'b1, 4'b0000, 32'd11, 32'd22}) begin
        failures++;
        $display("FAIL stall_hold: got rdy=%b v=%b op=%h i1=%0d i2=%0d required rdy=0 v=1 op=0 i1=11 i2=22",
                 if_ready, ex_valid, alu_op, alu_i1, alu_i2);
      end
      @(posedge clk); #1;
      rs1_data = ~rs1_data;
    end
    rs1_data = 32'd100;
    ex_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (if_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release: got if_ready=%b required 1", if_ready);
    end else begin
      sb.push_back(mk(4'b1000, 32'd100, 32'd40, 5'd3, 1'b1, 1'b0));
    end
    @(posedge clk); #1;
    if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b1 || alu_op !== 4'b1000 || alu_i1 !== 32'd100) begin
      failures++;
      $display("FAIL stall_next: got v=%b op=%h i1=%0d required v=1 op=8 i1=100", ex_valid, alu_op, alu_i1);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [11:0] imm;
    logic [4:0]  rd;
    ex_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imm = 12'(i * 1365);
      rd  = 5'(i);
      if_instr = {imm, 5'd2, 3'b000, rd, 7'b0010011};
      rs1_data = 32'h1000 + 32'(i);
      if_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (if_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready: got if_ready=%b required 1 at beat %0d", if_ready, i);
      end else begin
        sb.push_back(mk(4'b0000, 32'h1000 + 32'(i), {{20{imm[11]}}, imm}, rd, rd != 5'd0, 1'b0));
      end
      @(posedge clk); #1;
    end
    if_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    ex_ready = 1'b1;
    send(32'h123453B7, 32'h0, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'h1234_5000, 5'd7, 1'b1, 1'b0));
    if_instr = 32'h00000000; flush = 1'b1; if_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0 || illegal_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL flush_accept: got v=%b cnt=%0d required v=0 cnt=%0d", ex_valid, illegal_cnt, exp_cnt);
    end
    @(posedge clk); #1;
    ex_ready = 1'b0;
    send(32'h00001397, 32'h200, 32'h0, 32'h0, mk(4'b0000, 32'h200, 32'h0000_1000, 5'd7, 1'b1, 1'b0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_held: got v=%b required 0", ex_valid);
    end
    if (sb.size() > 0) void'(sb.pop_back());
    ex_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_stall();
    ex_ready = 1'b0;
    send(32'h00000000, 32'h0, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ex_valid, illegal, rd_we, alu_op, alu_i1, alu_i2, rd_addr, illegal_cnt} !== 84'h0) begin
      failures++;
      $display("FAIL async_reset: got v=%b ill=%b we=%b op=%h rd=%0d cnt=%0d required all zero",
               ex_valid, illegal, rd_we, alu_op, rd_addr, illegal_cnt);
    end
    sb.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1; ex_ready = 1'b1;
    if_instr = 32'h002081B3; rs1_data = 32'd1; rs2_data = 32'd2; if_valid = 1'b1;
    sb.push_back(mk(4'b0000, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0));
    @(posedge clk); #1;
    if_valid = 1'b0;
    checks++;
    if (ex_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_accept: got ex_valid=%b required 1", ex_valid);
    end
  endtask

  task automatic test_saturation();
    ex_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      send(32'h00000000, 32'h0, 32'h0, 32'h0, mk(4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    end
    @(negedge clk);
    checks++;
    if (illegal_cnt !== 8'd255) begin
      failures++;
      $display("FAIL cnt_saturate: got %0d required 255", illegal_cnt);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_op();
    test_opimm();
    test_upper();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d outstanding entries required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
